dbus_sram_responder: RTL and testbench

- Data-bus responder (slave end) for the pipeline memory stage. Accepts dbus_req_t requests and answers on dbus_resp_t from an internal 64-bit-word SRAM model.
- Response latency is configurable; byte-strobe writes are supported.
- Used as the backing data memory in simulation and as the template for the cache/bridge side of the data bus.

---
 rtl/dbus_sram_responder_if.sv | 43 ++++
 rtl/dbus_sram_responder.sv | 145 ++++++++++++++
 tb/tb_dbus_sram_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_responder_if.sv
// ---------------------------------------------------------------------------
// dbus_pkg / dbus_sram_responder_if
//
// Purpose : data-bus request/response types and the interface bundle used
//           between the pipeline memory stage (master) and a data-bus
//           responder such as dbus_sram_responder (slave).
//
// dbus_req_t  : valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
//               strobe == 0 means read.
// dbus_resp_t : addr_ok, data_ok, data[63:0]
//
// Modports:
//   master : drives dreq, observes dresp
//   slave  : observes dreq, drives dresp
// ---------------------------------------------------------------------------
package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

interface dbus_sram_responder_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder.sv
// ---------------------------------------------------------------------------
// dbus_sram_responder
//
// Purpose : slave end of the data bus backed by an internal SRAM model of
//           MEM_WORDS 64-bit words. Each accepted request is answered with a
//           single-cycle addr_ok/data_ok pulse LATENCY+2 cycles after valid
//           is first seen in IDLE. Writes use per-byte strobes; reads return
//           the whole 64-bit word (the requester does lane selection).
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   dbus   slave modport: dreq in, dresp out (registered)
//   busy   out  high while a request is latched and not yet answered
//   oor    out  sticky: an access fell outside the mapped window
//
// State table:
//   S_IDLE | waiting for dreq.valid; latches the request
//   S_WAIT | counting down the latency; valid dropping aborts the request
//   S_RESP | one-cycle response pulse on dresp
// ---------------------------------------------------------------------------
module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  dbus,
    output logic                  busy,
    output logic                  oor
);

    localparam int              IDX_W    = $clog2(MEM_WORDS);
    localparam int              CNT_W    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);
    localparam logic [63:0]     SPAN     = 64'(MEM_WORDS) << 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [7:0]       strobe_q;
    dbus_resp_t       dresp_q;
    logic             busy_q;
    logic             oor_q;

    logic [63:0]      mem_q [MEM_WORDS];

    logic [63:0]      off_d;
    logic             in_range_d;
    logic [IDX_W-1:0] idx_d;
    logic             done_d;
    logic             mem_we_d;

    // Access size only matters to the requester's lane shifting.
    logic             unused_size;
    assign unused_size = ^dbus.dreq.size;

    // Range check is done on the full 64-bit offset so addresses just past
    // the array never alias back onto low words.
    assign off_d      = addr_q - BASE_ADDR;
    assign in_range_d = (addr_q >= BASE_ADDR) && (off_d < SPAN);
    assign idx_d      = off_d[IDX_W+2:3];

    assign done_d   = (state_q == S_WAIT) && dbus.dreq.valid && (count_q == '0);
    assign mem_we_d = done_d && in_range_d && !reset;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem_q[idx_d][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            dresp_q  <= '0;
            busy_q   <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dbus.dreq.valid) begin
                        addr_q   <= dbus.dreq.addr;
                        wdata_q  <= dbus.dreq.data;
                        strobe_q <= dbus.dreq.strobe;
                        count_q  <= CNT_INIT;
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!dbus.dreq.valid) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (count_q == '0) begin
                        dresp_q.addr_ok <= 1'b1;
                        dresp_q.data_ok <= 1'b1;
                        // Writes and out-of-range reads answer with zero data.
                        dresp_q.data    <= ((strobe_q == 8'h00) && in_range_d) ? mem_q[idx_d] : 64'h0;
                        if (!in_range_d) begin
                            oor_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                S_RESP: begin
                    dresp_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    dresp_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dbus.dresp = dresp_q;
    assign busy       = busy_q;
    assign oor        = oor_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
    import dbus_pkg::*;

    logic clk;
    logic reset;
    logic busy2, oor2, busy0, oor0, busy5, oor5;

    dbus_sram_responder_if d2 ();
    dbus_sram_responder_if d0 ();
    dbus_sram_responder_if d5 ();

    dbus_sram_responder #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) u2 (
        .clk(clk), .reset(reset), .dbus(d2.slave), .busy(busy2), .oor(oor2));
    dbus_sram_responder #(.MEM_WORDS(64), .LATENCY(0), .BASE_ADDR(64'h8000_0000)) u0 (
        .clk(clk), .reset(reset), .dbus(d0.slave), .busy(busy0), .oor(oor0));
    dbus_sram_responder #(.MEM_WORDS(64), .LATENCY(5), .BASE_ADDR(64'h8000_0000)) u5 (
        .clk(clk), .reset(reset), .dbus(d5.slave), .busy(busy5), .oor(oor5));

    int errors = 0;
    int checks = 0;

    logic [63:0] rd;
    logic [63:0] sb [4];
    logic [63:0] a, d;
    logic [7:0]  s;
    int          w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pipeline-initiator style access on the LATENCY=2 instance: hold the
    // request until the ok cycle, clear it there, return one cycle later.
    task automatic access(input string tag, input logic [63:0] addr, input logic [7:0] strb,
                          input logic [63:0] data, output logic [63:0] rdata);
        int lat;
        lat   = 0;
        rdata = '0;
        d2.dreq.valid  = 1'b1;
        d2.dreq.addr   = addr;
        d2.dreq.size   = 3'd3;
        d2.dreq.strobe = strb;
        d2.dreq.data   = data;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d2.dresp.data_ok === 1'b1) begin
                lat   = k;
                rdata = d2.dresp.data;
                chk({tag, " addr_ok"}, 64'(d2.dresp.addr_ok), 64'd1);
                chk({tag, " busy@resp"}, 64'(busy2), 64'd1);
                break;
            end
            chk({tag, " busy wait"}, 64'(busy2), 64'd1);
            chk({tag, " addr_ok early"}, 64'(d2.dresp.addr_ok), 64'd0);
        end
        chk({tag, " latency"}, 64'(lat), 64'd4);
        d2.dreq = '0;
        @(negedge clk);
        chk({tag, " single pulse"}, 64'({d2.dresp.addr_ok, d2.dresp.data_ok}), 64'd0);
        chk({tag, " busy after"}, 64'(busy2), 64'd0);
    endtask

    initial begin
        d2.dreq = '0;
        d0.dreq = '0;
        d5.dreq = '0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dresp", 64'({d2.dresp.addr_ok, d2.dresp.data_ok}), 64'd0);
        chk("reset data", d2.dresp.data, 64'd0);
        chk("reset busy", 64'(busy2), 64'd0);
        chk("reset oor", 64'(oor2), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // write then read back
        access("wr 10", 64'h8000_0010, 8'hff, 64'h1122_3344_5566_7788, rd);
        chk("wr 10 data", rd, 64'h0);
        access("rd 10", 64'h8000_0010, 8'h00, 64'h0, rd);
        chk("rd 10 data", rd, 64'h1122_3344_5566_7788);

        // byte strobe merge
        access("wr 0 full", 64'h8000_0000, 8'hff, 64'hffff_ffff_ffff_ffff, rd);
        access("wr 3 byte", 64'h8000_0003, 8'h08, 64'h0000_0000_ab00_0000, rd);
        access("rd 0", 64'h8000_0003, 8'h00, 64'h0, rd);
        chk("byte strobe data", rd, 64'hffff_ffff_abff_ffff);

        // abort: valid dropped while in WAIT
        d2.dreq.valid  = 1'b1;
        d2.dreq.addr   = 64'h8000_0010;
        d2.dreq.strobe = 8'hff;
        d2.dreq.data   = 64'hdead_beef_dead_beef;
        @(negedge clk);
        chk("abort busy in wait", 64'(busy2), 64'd1);
        d2.dreq.valid = 1'b0;
        @(negedge clk);
        chk("abort idle", 64'(busy2), 64'd0);
        d2.dreq = '0;
        for (int k = 0; k < 4; k++) begin
            chk("abort no resp", 64'({d2.dresp.addr_ok, d2.dresp.data_ok}), 64'd0);
            @(negedge clk);
        end
        access("rd after abort", 64'h8000_0010, 8'h00, 64'h0, rd);
        chk("abort no write", rd, 64'h1122_3344_5566_7788);

        // reset while a write is waiting
        d2.dreq.valid  = 1'b1;
        d2.dreq.addr   = 64'h8000_0010;
        d2.dreq.strobe = 8'hff;
        d2.dreq.data   = 64'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst wait busy", 64'(busy2), 64'd0);
        chk("rst wait dresp", 64'({d2.dresp.addr_ok, d2.dresp.data_ok}), 64'd0);
        reset   = 1'b0;
        d2.dreq = '0;
        @(negedge clk);
        access("rd after rst", 64'h8000_0010, 8'h00, 64'h0, rd);
        chk("rst no write", rd, 64'h1122_3344_5566_7788);

        // range boundaries and sticky oor
        access("wr last", 64'h8000_7ff8, 8'hff, 64'h0f0e_0d0c_0b0a_0908, rd);
        access("rd last", 64'h8000_7ff8, 8'h00, 64'h0, rd);
        chk("last word data", rd, 64'h0f0e_0d0c_0b0a_0908);
        chk("oor clear legal", 64'(oor2), 64'd0);
        access("rd low oor", 64'h0000_1000, 8'h00, 64'h0, rd);
        chk("oor read data", rd, 64'h0);
        chk("oor set", 64'(oor2), 64'd1);
        access("wr past end", 64'h8000_8000, 8'hff, 64'h0, rd);
        access("rd 0 again", 64'h8000_0000, 8'h00, 64'h0, rd);
        chk("no alias write", rd, 64'hffff_ffff_abff_ffff);
        chk("oor sticky", 64'(oor2), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("oor reset", 64'(oor2), 64'd0);
        @(negedge clk);

        // back-to-back mixed traffic against a scoreboard
        for (int i = 0; i < 16; i++) begin
            w = i % 4;
            a = 64'h8000_0100 + 64'(w * 8);
            if (i < 4 || (i % 3) == 1) begin
                s = (i < 4) ? 8'hff : (8'ha5 ^ 8'(i * 29));
                d = 64'h0123_4567_89ab_cdef ^ (64'(i) * 64'h1111_1111_1111_1111);
                access("b2b wr", a, s, d, rd);
                chk("b2b wr data", rd, 64'h0);
                for (int j = 0; j < 8; j++) begin
                    if (s[j]) sb[w][8*j +: 8] = d[8*j +: 8];
                end
            end else begin
                access("b2b rd", a, 8'h00, 64'h0, rd);
                chk("b2b rd data", rd, sb[w]);
            end
        end

        // latency sweep: LATENCY=0 answers at k=2, LATENCY=5 at k=7
        d0.dreq.valid  = 1'b1;
        d0.dreq.addr   = 64'h8000_0008;
        d0.dreq.size   = 3'd3;
        d0.dreq.strobe = 8'hff;
        d0.dreq.data   = 64'h55;
        d5.dreq        = d0.dreq;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("lat0 ok", 64'({d0.dresp.addr_ok, d0.dresp.data_ok}), (k == 2) ? 64'd3 : 64'd0);
            chk("lat0 busy", 64'(busy0), (k <= 2) ? 64'd1 : 64'd0);
            chk("lat5 ok", 64'({d5.dresp.addr_ok, d5.dresp.data_ok}), (k == 7) ? 64'd3 : 64'd0);
            chk("lat5 busy", 64'(busy5), (k <= 7) ? 64'd1 : 64'd0);
            if (k == 2) d0.dreq = '0;
            if (k == 7) d5.dreq = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
